// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e   : controller states (2-bit encoding)
//   cnt_w()   : digit counter width, at least one bit
//   digit_ok(): legal WIDTH/DIGIT combination check
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter only has to reach CYCLES-1; keep one bit for the single-cycle case.
  function automatic int cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && (width % digit == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
//   master : producer/consumer side (drives operands, out_ready)
//   slave  : the adder (drives in_ready and the result)
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );
endinterface

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
//   a, b : digit operands
//   cin  : carry in
//   s    : digit sum
//   cout : carry out of the top bit
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[DIGIT];
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered
// carry, CYCLES = WIDTH/DIGIT run cycles per operation.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : operand/result handshake (slave side)
//   busy : controller not idle
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus,
  output logic            busy
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CNT_W  = cnt_w(CYCLES);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_param_err
    $fatal(1, "serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d, b_eff;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, ovf_d;
  logic             last;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;

  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a    (a_sh_q[DIGIT-1:0]),
    .b    (b_sh_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Subtract is A + ~B + 1: invert B on entry and seed the carry with 1.
  assign b_eff    = bus.in_sub ? ~bus.in_b : bus.in_b;
  // New digit enters at the top; after CYCLES shifts the LSB digit is at bit 0.
  assign sum_sh_d = (sum_sh_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign last     = (cnt_q == CNT_W'(CYCLES - 1));
  assign ovf_d    = (a_msb_q == b_msb_q) && (sum_sh_d[WIDTH-1] != a_msb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_sh_q  <= bus.in_a;
          b_sh_q  <= b_eff;
          carry_q <= bus.in_sub;
          cnt_q   <= '0;
          a_msb_q <= bus.in_a[WIDTH-1];
          b_msb_q <= b_eff[WIDTH-1];
          state_q <= RUN;
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> DIGIT;
          b_sh_q   <= b_sh_q >> DIGIT;
          sum_sh_q <= sum_sh_d;
          carry_q  <= dig_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last) begin
            sum_q   <= sum_sh_d;
            cout_q  <= dig_c;
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed table + corner sequences on WIDTH=8/DIGIT=2,
// randomized runs on WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8 against an
// arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as given.
  function automatic void ref_model(input int w, input int a, input int b, input bit sub,
                                    output int sum, output bit c, output bit ovf);
    int m, sa, sb, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      sum = (a - b + m) % m;
      c   = (a >= b);
      sr  = sa - sb;
    end else begin
      sum = (a + b) % m;
      c   = ((a + b) >= m);
      sr  = sa + sb;
    end
    ovf = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  // ---------------- WIDTH=8, DIGIT=2 instance (directed) ----------------
  serial_addsub_if #(.WIDTH(8)) b0 ();
  logic rst0;
  logic busy0;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk  (clk),
    .rst  (rst0),
    .bus  (b0),
    .busy (busy0)
  );

  task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic sub, output int lat);
    int guard;
    @(negedge clk);
    b0.in_a = a; b0.in_b = b; b0.in_sub = sub; b0.in_valid = 1'b1;
    guard = 0;
    while (!b0.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    lat = 0;
    while (!b0.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack0();
    @(negedge clk); b0.out_ready = 1'b1;
    @(posedge clk); #1 b0.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       c;
    logic       ovf;
  } vec_t;

  // ---------------- randomized instances ----------------
  for (genvar g = 0; g < 2; g++) begin : rnd
    localparam int W   = (g == 0) ? 16 : 8;
    localparam int D   = (g == 0) ? 4  : 8;
    localparam int CYC = W / D;

    serial_addsub_if #(.WIDTH(W)) bi ();
    logic rst_r;
    logic busy_r;
    logic done;

    serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
      .clk  (clk),
      .rst  (rst_r),
      .bus  (bi),
      .busy (busy_r)
    );

    initial begin
      int a, b, es, lat, guard, stall;
      bit s, ec, eo;
      string tag;
      tag  = $sformatf("w%0dd%0d", W, D);
      done = 1'b0;
      bi.in_valid = 1'b0; bi.in_a = '0; bi.in_b = '0; bi.in_sub = 1'b0; bi.out_ready = 1'b0;
      rst_r = 1'b1;
      repeat (2) @(negedge clk);
      rst_r = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        a = int'($urandom_range(0, (1 << W) - 1));
        b = int'($urandom_range(0, (1 << W) - 1));
        s = 1'($urandom_range(0, 1));
        ref_model(W, a, b, s, es, ec, eo);
        @(negedge clk);
        bi.in_a = W'(a); bi.in_b = W'(b); bi.in_sub = s; bi.in_valid = 1'b1;
        guard = 0;
        while (!bi.in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1 bi.in_valid = 1'b0;
        lat = 0;
        // out_ready toggles randomly during RUN; it must have no effect there.
        while (!bi.out_valid && lat < 50) begin
          bi.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1; lat++;
        end
        bi.out_ready = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(CYC));
        chk({tag, " sum"},     32'(bi.out_sum),   32'(es));
        chk({tag, " carry"},   32'(bi.out_carry), 32'(ec));
        chk({tag, " ovf"},     32'(bi.out_ovf),   32'(eo));
        stall = int'($urandom_range(0, 3));
        repeat (stall) begin
          @(negedge clk);
          chk({tag, " stall valid"}, 32'(bi.out_valid), 32'd1);
          chk({tag, " stall sum"},   32'(bi.out_sum),   32'(es));
        end
        @(negedge clk); bi.out_ready = 1'b1;
        @(posedge clk); #1 bi.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence + summary ----------------
  initial begin
    vec_t tbl[7];
    int   lat, guard;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};

    b0.in_valid = 1'b0; b0.in_a = '0; b0.in_b = '0; b0.in_sub = 1'b0; b0.out_ready = 1'b0;
    rst0 = 1'b1;
    #2;
    chk("rst out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst busy",      32'(busy0),        32'd0);
    chk("rst in_ready",  32'(b0.in_ready),  32'd0);
    chk("rst out_sum",   32'(b0.out_sum),   32'd0);
    chk("rst carry",     32'(b0.out_carry), 32'd0);
    chk("rst ovf",       32'(b0.out_ovf),   32'd0);
    @(negedge clk); @(negedge clk);
    rst0 = 1'b0;
    #1 chk("post-rst in_ready", 32'(b0.in_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run0(tbl[i].a, tbl[i].b, tbl[i].sub, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat),          32'd4);
      chk($sformatf("vec%0d sum", i),     32'(b0.out_sum),   32'(tbl[i].sum));
      chk($sformatf("vec%0d carry", i),   32'(b0.out_carry), 32'(tbl[i].c));
      chk($sformatf("vec%0d ovf", i),     32'(b0.out_ovf),   32'(tbl[i].ovf));
      ack0();
    end

    // Backpressure: hold DONE for 5 cycles, poke in_valid with new operands.
    run0(8'h12, 8'h34, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) begin b0.in_a = 8'hAA; b0.in_b = 8'h55; b0.in_sub = 1'b1; b0.in_valid = 1'b1; end
      else b0.in_valid = 1'b0;
      chk("bp out_valid", 32'(b0.out_valid), 32'd1);
      chk("bp in_ready",  32'(b0.in_ready),  32'd0);
      chk("bp out_sum",   32'(b0.out_sum),   32'h46);
    end
    @(negedge clk); b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    @(posedge clk); #1 b0.out_ready = 1'b0;
    chk("bp release out_valid", 32'(b0.out_valid), 32'd0);
    chk("bp release in_ready",  32'(b0.in_ready),  32'd1);
    chk("bp release busy",      32'(busy0),        32'd0);
    chk("bp held out_sum",      32'(b0.out_sum),   32'h46);

    // Reset in the middle of RUN (cnt == 2).
    @(negedge clk);
    b0.in_a = 8'h33; b0.in_b = 8'h11; b0.in_sub = 1'b0; b0.in_valid = 1'b1;
    guard = 0;
    while (!b0.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 b0.in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 chk("mid-run busy", 32'(busy0), 32'd1);
    rst0 = 1'b1;
    #1;
    chk("abort out_valid", 32'(b0.out_valid), 32'd0);
    chk("abort busy",      32'(busy0),        32'd0);
    chk("abort in_ready",  32'(b0.in_ready),  32'd0);
    chk("abort out_sum",   32'(b0.out_sum),   32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    #1 chk("abort release in_ready", 32'(b0.in_ready), 32'd1);
    run0(8'h01, 8'h02, 1'b0, lat);
    chk("fresh latency", 32'(lat),          32'd4);
    chk("fresh sum",     32'(b0.out_sum),   32'h03);
    chk("fresh carry",   32'(b0.out_carry), 32'd0);
    ack0();

    guard = 0;
    while (!(rnd[0].done && rnd[1].done) && guard < 60000) begin @(negedge clk); guard++; end
    if (!(rnd[0].done && rnd[1].done)) begin
      nvec++; nerr++;
      $display("FAIL random timeout: done=%b%b, want 11", rnd[0].done, rnd[1].done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor; successor to the single-bit combinational half-adder tile.
- Accepts two WIDTH-bit operands over a valid/ready handshake and processes DIGIT bits per clock through a registered carry chain.
- Presents sum, carry/borrow and signed-overflow results over a second valid/ready handshake.
- Sits behind the tile I/O wrapper; trades latency for area on a small tile.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH exactly. DIGIT = WIDTH gives single-cycle operation.
- CYCLES (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept an operand.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_carry  out  1  carry out of MSB. For subtract: 1 = no borrow (A ≥ B unsigned).
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (async assert, sync release): state = IDLE, all datapath and result registers = 0. During reset, out_valid = 0, busy = 0 and in_ready = 0.
- in_ready = (state == IDLE) && !rst. out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready: latch a_sh = in_a and b_sh = in_sub ? ~in_b : in_b.
  - Set carry = in_sub, cnt = 0, latch a_msb = in_a[WIDTH-1] and b_msb = effective b MSB.
  - Go to RUN.
- RUN, every cycle:
  - digit_adder adds a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
  - The DIGIT-bit result shifts into the top of sum_sh (sum_sh shifts right by DIGIT); a_sh and b_sh shift right by DIGIT; carry takes the digit carry-out; cnt increments.
  - When cnt == CYCLES−1, the final digit completes and the state goes to DONE at the same edge.
  - On that edge, out_sum = final sum_sh, out_carry = final carry, and out_ovf = (a_msb == b_msb) && (sum MSB != a_msb).
- DONE:
  - out_valid = 1; out_sum, out_carry and out_ovf are held stable.
  - On out_ready, go to IDLE at that edge.
  - out_ready while not in DONE is ignored.
- Latency: accept edge E; out_valid is high in the cycle after edge E+CYCLES. DIGIT = WIDTH gives out_valid one cycle after acceptance.
- Minimum initiation interval is CYCLES+2 cycles: no accept in DONE, and there is one IDLE cycle.
- Result outputs keep the last completed result after leaving DONE, until the next completion. Consumers must qualify with out_valid.
- in_valid during RUN or DONE is ignored (in_ready = 0), and no operand is latched.
- Reset mid-RUN or mid-DONE aborts the operation. The result is lost and out_valid drops asynchronously.
- Arithmetic is unsigned modulo 2^WIDTH. The overflow flag is computed on the effective operands, so it is correct for both add and subtract.

Decomposition:
- Shared package `addsub_pkg`:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - function clog2-based counter width, CNT_W = max(1, clog2(CYCLES)).
  - parameter-check constants (WIDTH % DIGIT == 0).
- One sub-module, `digit_adder`:
  - purely combinational DIGIT-bit ripple adder.
  - inputs a, b, cin; outputs s, cout.
  - reuses the half/full-adder equations (sum = a^b^c, carry = majority).
- Top level holds the FSM, shift registers, counter and result registers.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- 0x5A + 0x3C, sub=0 → out_sum=0x96, carry=0, ovf=1; out_valid rises exactly 4 cycles after the accept edge.
- 0xFF + 0x01, sub=0 → out_sum=0x00, carry=1, ovf=0. Also 0x00 + 0x00 → 0x00, carry=0, ovf=0.
- Subtract: 0x10 − 0x20 → 0xF0, carry=0, ovf=0. 0x80 − 0x01 → 0x7F, carry=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, an in_valid pulse with new operands is ignored. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Reset during RUN (cnt=2) → out_valid=0, busy=0 immediately. After release, in_ready=1 and a fresh 0x01 + 0x02 returns 0x03.
- Parameter sweep WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=8:
  - 1000 random operations with random in_sub and random out_ready stalls.
  - compare against the reference model (sum, carry, ovf) and check latency = CYCLES.
